simple_prog_loader: RTL and testbench

SIMPLE_PROG_LOADER -- requirements
Module: simple_prog_loader

---
 rtl/simple_pkg.sv | 19 +
 rtl/simple_xor_csum.sv | 22 ++
 rtl/simple_prog_loader.sv | 129 ++++++++++++
 tb/tb_simple_prog_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared types and sizes for the serial program loader.
// Holds the loader state encoding and instruction geometry.
package simple_pkg;

  localparam int IMEM_AW_DEF = 8;
  localparam int INSTR_W     = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    WR,
    CSUM,
    DONE,
    ERR
  } ld_state_t;

endpackage

// File: rtl/simple_xor_csum.sv
// Running 8-bit XOR over the accepted stream bytes.
// Clear wins over enable so a new load starts from zero.
module simple_xor_csum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= 8'h00;
    end else if (clear) begin
      sum <= 8'h00;
    end else if (en) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/simple_prog_loader.sv
// Byte-stream program loader: length, N big-endian words, checksum.
// Holds the CPU in reset until a complete, verified image is written.
module simple_prog_loader
  import simple_pkg::*;
#(
  parameter int CSUM_EN = 1,
  parameter int IMEM_AW = IMEM_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready,
  output logic               imem_wren,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               cpu_resetn
);

  localparam int CNT_W = IMEM_AW + 1;

  ld_state_t         state_q;
  ld_state_t         state_d;
  logic [CNT_W-1:0]  idx_q;
  logic [CNT_W-1:0]  n_q;
  logic [7:0]        hi_q;
  logic [7:0]        csum;
  logic              take;
  logic              start_ok;
  logic              last;
  logic              csum_en;

  assign s_ready = state_q inside {LEN, HI, LO, CSUM};
  assign busy    = state_q inside {LEN, HI, LO, WR, CSUM};
  assign done    = (state_q == DONE);
  assign err     = (state_q == ERR);

  assign cpu_resetn = (state_q == DONE);
  assign imem_wren  = (state_q == WR);

  assign take     = s_valid && s_ready;
  assign start_ok = start && (state_q inside {IDLE, DONE, ERR});
  assign last     = (idx_q + CNT_W'(1)) == n_q;
  assign csum_en  = take && (state_q inside {LEN, HI, LO});

  simple_xor_csum u_csum (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .en    (csum_en),
    .din   (s_data),
    .sum   (csum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = LEN;
      end
      LEN: begin
        if (take) state_d = HI;
      end
      HI: begin
        if (take) state_d = LO;
      end
      LO: begin
        if (take) state_d = WR;
      end
      WR: begin
        if (!last)
          state_d = HI;
        else if (CSUM_EN != 0)
          state_d = CSUM;
        else
          state_d = DONE;
      end
      CSUM: begin
        if (take)
          state_d = (s_data == csum) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // A zero length byte encodes the full instruction space.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q      <= '0;
      n_q        <= '0;
      hi_q       <= 8'h00;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      if (start_ok) begin
        idx_q <= '0;
      end
      if (state_q == LEN && take) begin
        if (s_data == 8'h00)
          n_q <= CNT_W'(1) << IMEM_AW;
        else
          n_q <= CNT_W'(s_data);
      end
      if (state_q == HI && take) begin
        hi_q <= s_data;
      end
      if (state_q == LO && take) begin
        imem_waddr <= idx_q[IMEM_AW-1:0];
        imem_wdata <= {hi_q, s_data};
      end
      if (state_q == WR) begin
        idx_q <= idx_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_simple_prog_loader.sv
// Directed bench for simple_prog_loader with a write-capture model.
// Drives and samples on the falling edge.
module tb_simple_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        imem_wren;
  logic [7:0]  imem_waddr;
  logic [15:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_resetn;

  int n_checks = 0;
  int n_err    = 0;
  int wcount   = 0;
  int exp_addr = 0;
  int base;
  int bad;

  logic [15:0] mem   [256];
  logic [15:0] words [256];

  simple_prog_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_wren  (imem_wren),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_resetn (cpu_resetn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Capture writes; expected address restarts whenever the loader is idle.
  always @(negedge clk) begin
    if (!busy) exp_addr = 0;
    if (imem_wren) begin
      check("wr_ready", 32'(s_ready), 32'd0);
      check("wr_addr", 32'(imem_waddr), 32'(exp_addr));
      mem[imem_waddr] = imem_wdata;
      wcount++;
      exp_addr++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int k;
    if (gap) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    k = 0;
    while (!s_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!s_ready) check("byte_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic load(input int n,
                      input logic [7:0] cs,
                      input bit gap);
    pulse_start();
    send_byte(8'(n), gap);
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][15:8], gap);
      send_byte(words[i][7:0], gap);
    end
    send_byte(cs, gap);
    s_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_wren", 32'(imem_wren), 0);
    check("rst_waddr", 32'(imem_waddr), 0);
    check("rst_wdata", 32'(imem_wdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_cpu", 32'(cpu_resetn), 0);
    reset = 1'b0;
    @(negedge clk);

    // Two-word load with a correct checksum
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    base = wcount;
    load(2, 8'h42, 1'b0);
    check("ok_done", 32'(done), 1);
    check("ok_err", 32'(err), 0);
    check("ok_cpu", 32'(cpu_resetn), 1);
    check("ok_busy", 32'(busy), 0);
    check("ok_wcnt", 32'(wcount - base), 2);
    check("ok_mem0", 32'(mem[0]), 32'h1234);
    check("ok_mem1", 32'(mem[1]), 32'hABCD);
    repeat (3) @(negedge clk);
    check("hold_addr", 32'(imem_waddr), 1);
    check("hold_data", 32'(imem_wdata), 32'hABCD);
    check("sticky_done", 32'(done), 1);

    // Same stream, wrong checksum
    load(2, 8'h00, 1'b0);
    check("bad_err", 32'(err), 1);
    check("bad_done", 32'(done), 0);
    check("bad_cpu", 32'(cpu_resetn), 0);

    // Full 256-word image; pairs cancel so checksum is 00
    for (int i = 0; i < 256; i++) words[i] = {8'(i), 8'(i)};
    base = wcount;
    load(256, 8'h00, 1'b0);
    check("full_done", 32'(done), 1);
    check("full_wcnt", 32'(wcount - base), 256);
    check("full_m0", 32'(mem[0]), 32'h0000);
    check("full_m128", 32'(mem[128]), 32'h8080);
    check("full_m255", 32'(mem[255]), 32'hFFFF);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== {8'(i), 8'(i)}) bad++;
    check("full_image", 32'(bad), 0);

    // Random valid gaps
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    base = wcount;
    load(2, 8'h42, 1'b1);
    check("gap_done", 32'(done), 1);
    check("gap_wcnt", 32'(wcount - base), 2);
    check("gap_mem0", 32'(mem[0]), 32'h1234);
    check("gap_mem1", 32'(mem[1]), 32'hABCD);
    check("gap_mem2", 32'(mem[2]), 32'h0202);

    // Reset after the high byte of word 1
    base = wcount;
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    s_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_busy", 32'(busy), 0);
    check("mid_cpu", 32'(cpu_resetn), 0);
    check("mid_waddr", 32'(imem_waddr), 0);
    check("mid_wdata", 32'(imem_wdata), 0);
    reset   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hCD;
    repeat (4) @(negedge clk);
    check("mid_ready", 32'(s_ready), 0);
    check("mid_wcnt", 32'(wcount - base), 1);
    check("mid_mem0", 32'(mem[0]), 32'h1234);
    s_valid = 1'b0;
    load(2, 8'h42, 1'b0);
    check("reload_done", 32'(done), 1);
    check("reload_mem1", 32'(mem[1]), 32'hABCD);

    // Start while in HI is ignored
    base = wcount;
    pulse_start();
    send_byte(8'h02, 1'b0);
    s_valid = 1'b0;
    pulse_start();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b0);
    send_byte(8'h42, 1'b0);
    s_valid = 1'b0;
    check("hi_done", 32'(done), 1);
    check("hi_wcnt", 32'(wcount - base), 2);
    check("hi_mem1", 32'(mem[1]), 32'hABCD);

    // Start while in DONE restarts immediately
    pulse_start();
    check("rs_done", 32'(done), 0);
    check("rs_cpu", 32'(cpu_resetn), 0);
    check("rs_busy", 32'(busy), 1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hFE, 1'b0);
    s_valid = 1'b0;
    check("rs_fin", 32'(done), 1);
    check("rs_mem0", 32'(mem[0]), 32'h55AA);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
